// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: field limits,
// special segment patterns and the scan-slot ordering.
package stopwatch_pkg;

    localparam logic [6:0] CS_MAX  = 7'd99;
    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Scan slot order, rightmost digit first.
    typedef enum logic [2:0] {
        DIG_CS0  = 3'd0,
        DIG_CS1  = 3'd1,
        DIG_SEC0 = 3'd2,
        DIG_SEC1 = 3'd3,
        DIG_MIN0 = 3'd4,
        DIG_MIN1 = 3'd5,
        DIG_HR0  = 3'd6,
        DIG_HR1  = 3'd7
    } digit_e;

endpackage

// File: rtl/stopwatch_display_if.sv
// Time/control bus from the stopwatch counter to the display stage.
interface stopwatch_display_if;

    logic       running;
    logic       reset_edge;
    logic       lap_edge;
    logic [6:0] centiseconds;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;

    modport master (
        output running, reset_edge, lap_edge,
        output centiseconds, seconds, minutes, hours
    );

    modport slave (
        input running, reset_edge, lap_edge,
        input centiseconds, seconds, minutes, hours
    );

endinterface

// File: rtl/seg7_encode.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; dash overrides.
module seg7_encode
    import stopwatch_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] pattern
);

    // Pattern lookup; non-decimal codes fall back to blank.
    always_comb begin
        pattern = SEG_BLANK;
        if (dash) begin
            pattern = SEG_DASH;
        end else begin
            case (digit)
                4'd0:    pattern = 7'h40;
                4'd1:    pattern = 7'h79;
                4'd2:    pattern = 7'h24;
                4'd3:    pattern = 7'h30;
                4'd4:    pattern = 7'h19;
                4'd5:    pattern = 7'h12;
                4'd6:    pattern = 7'h02;
                4'd7:    pattern = 7'h78;
                4'd8:    pattern = 7'h00;
                4'd9:    pattern = 7'h10;
                default: pattern = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed 8-digit HH.MM.SS.CC display driver with lap hold,
// frame-aligned latching and a blinking separator while stopped.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 1,
    parameter int unsigned BLINK_HALF = 500
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clock_1ms,
    stopwatch_display_if.slave  time_bus,
    output logic [7:0]          anode,
    output logic [6:0]          segments,
    output logic                dp,
    output logic                hold
);

    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 0) ? $clog2(2 * BLINK_HALF) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_MID  = BLINK_W'(BLINK_HALF);

    logic               clock_1ms_prev;
    logic               tick;
    logic               slot_end;
    logic               frame_wrap;
    logic [DIV_W-1:0]   div;
    logic [2:0]         scan_idx;
    logic [BLINK_W-1:0] blink_cnt;

    logic [6:0] disp_cs;
    logic [5:0] disp_s;
    logic [5:0] disp_m;
    logic [4:0] disp_h;

    logic [6:0] sel_val;
    logic [6:0] sel_max;
    logic       sel_tens;
    logic       separator;
    logic [3:0] digit;
    logic       dash;
    logic [6:0] seg_next;
    logic       dp_next;

    assign tick       = clock_1ms & ~clock_1ms_prev;
    assign slot_end   = tick && (div == DIV_LAST);
    assign frame_wrap = slot_end && (scan_idx == 3'd7);

    // Rising-edge detect of the 1 ms level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) clock_1ms_prev <= 1'b0;
        else          clock_1ms_prev <= clock_1ms;
    end

    // Digit slot timer and scan index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div      <= '0;
            scan_idx <= '0;
        end else if (tick) begin
            if (slot_end) begin
                div      <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    // Free-running separator blink counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       blink_cnt <= '0;
        else if (tick) begin
            if (blink_cnt == BLINK_LAST) blink_cnt <= '0;
            else                         blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Lap hold and display latches; clear beats lap, lap-on snapshots
    // immediately, lap-off waits for the next frame wrap to reload.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold    <= 1'b0;
            disp_cs <= '0;
            disp_s  <= '0;
            disp_m  <= '0;
            disp_h  <= '0;
        end else if (time_bus.reset_edge) begin
            hold    <= 1'b0;
            disp_cs <= '0;
            disp_s  <= '0;
            disp_m  <= '0;
            disp_h  <= '0;
        end else if (time_bus.lap_edge && !hold) begin
            hold    <= 1'b1;
            disp_cs <= time_bus.centiseconds;
            disp_s  <= time_bus.seconds;
            disp_m  <= time_bus.minutes;
            disp_h  <= time_bus.hours;
        end else if (time_bus.lap_edge) begin
            hold <= 1'b0;
        end else if (!hold && frame_wrap) begin
            disp_cs <= time_bus.centiseconds;
            disp_s  <= time_bus.seconds;
            disp_m  <= time_bus.minutes;
            disp_h  <= time_bus.hours;
        end
    end

    // Select the field for the current slot and split into tens/units.
    always_comb begin
        sel_val   = disp_cs;
        sel_max   = CS_MAX;
        sel_tens  = 1'b0;
        separator = 1'b0;
        case (digit_e'(scan_idx))
            DIG_CS0:  begin sel_val = disp_cs;         sel_max = CS_MAX; end
            DIG_CS1:  begin sel_val = disp_cs;         sel_max = CS_MAX;         sel_tens = 1'b1; end
            DIG_SEC0: begin sel_val = {1'b0, disp_s};  sel_max = {1'b0, SEC_MAX}; separator = 1'b1; end
            DIG_SEC1: begin sel_val = {1'b0, disp_s};  sel_max = {1'b0, SEC_MAX}; sel_tens = 1'b1; end
            DIG_MIN0: begin sel_val = {1'b0, disp_m};  sel_max = {1'b0, MIN_MAX}; separator = 1'b1; end
            DIG_MIN1: begin sel_val = {1'b0, disp_m};  sel_max = {1'b0, MIN_MAX}; sel_tens = 1'b1; end
            DIG_HR0:  begin sel_val = {2'b0, disp_h};  sel_max = {2'b0, HR_MAX};  separator = 1'b1; end
            DIG_HR1:  begin sel_val = {2'b0, disp_h};  sel_max = {2'b0, HR_MAX};  sel_tens = 1'b1; end
            default:  begin sel_val = disp_cs;         sel_max = CS_MAX; end
        endcase
        dash    = sel_val > sel_max;
        digit   = sel_tens ? 4'(sel_val / 7'd10) : 4'(sel_val % 7'd10);
        dp_next = ~(separator && (time_bus.running || (blink_cnt < BLINK_MID)));
    end

    seg7_encode u_seg7_encode (
        .digit   (digit),
        .dash    (dash),
        .pattern (seg_next)
    );

    // Registered, active-low display outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anode    <= '1;
            segments <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            anode    <= ~(8'b1 << scan_idx);
            segments <= seg_next;
            dp       <= dp_next;
        end
    end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Downstream display stage of the stopwatch. Takes the binary time fields (centiseconds, seconds, minutes, hours) and run flag from the stopwatch counter and drives an 8-digit multiplexed common-anode 7-segment display as HH.MM.SS.CC. Adds a lap-hold freeze, tear-free frame latching, and a blinking separator while stopped. All outputs are active-low and registered.

## Interface
- SCAN_DIV, default 1: 1 ms ticks per digit slot. Default gives 8 ms frame, 125 Hz refresh.
- BLINK_HALF, default 500: 1 ms ticks per half-period of the stopped-state DP blink.
- clock  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- clock_1ms  in  1  1 kHz level tick; rising edge detected internally
- running  in  1  counter run flag
- reset_edge  in  1  one-clock pulse, stopwatch clear
- lap_edge  in  1  one-clock pulse, toggle lap hold
- centiseconds  in  7  0..99
- seconds  in  6  0..59
- minutes  in  6  0..59
- hours  in  5  0..23
- anode  out  8  digit enables, active-low; bit 0 = rightmost digit
- segments  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- hold  out  1  lap hold active

## Operation
- Tick: tick = clock_1ms & ~clock_1ms_prev; prev register resets to 0.
- Scan: div counter 0..SCAN_DIV-1 advances on tick. On tick with div = SCAN_DIV-1, div goes to 0 and scan_idx (3 bits) increments, wrapping 7→0.
- Digit map by scan_idx 0..7: cs units, cs tens, s units, s tens, m units, m tens, h units, h tens.
- Split: field / 10 gives tens, field % 10 gives units.
- Out-of-range field (cs>99, s>59, m>59, h>23): both digits of that field show dash, 7'h3F.
- Encoding: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Blank=7'h7F. No leading-zero blanking.
- DP: lit only on scan_idx 2, 4 and 6.
  - While running=1: steady.
  - While running=0: lit when blink_cnt < BLINK_HALF.
  - blink_cnt counts 0..2*BLINK_HALF-1 on tick, free-running.
- Display registers disp_cs, disp_s, disp_m, disp_h:
  - Live mode (hold=0): load inputs on the clock where scan_idx wraps 7→0.
  - Held mode: frozen.
- Hold rules:
  - lap_edge with hold=0: hold←1 and display registers load inputs the same clock (snapshot).
  - lap_edge with hold=1: hold←0; live loading resumes at the next frame wrap.
  - reset_edge: hold←0 and display registers←0 the same clock. Takes priority over a simultaneous lap_edge.
  - Counting upstream is unaffected by hold.

## Timing
- Reset values:
  - anode=8'hFF, segments=7'h7F, dp=1, hold=0.
  - scan_idx=0, div=0, blink_cnt=0, display registers=0.
- Outputs are registered from scan_idx and the display registers, 1 clock latency. After a scan_idx change, anode/segments/dp reflect the new digit on the next edge.
- Exactly one anode bit is low at any time after the first post-reset clock.
- Held snapshot is visible within at most 1 digit slot plus 1 clock.
- Reset mid-frame forces reset values immediately (asynchronous) and restarts the scan at digit 0.

## Structure
- Package stopwatch_pkg holds:
  - field maxima CS_MAX=99, SEC_MAX=59, MIN_MAX=59, HR_MAX=23
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F
  - digit index constants DIG_CS0..DIG_HR1
- One sub-module, seg7_encode: 4-bit digit plus dash flag in, 7-bit active-low pattern out, combinational.
- Scan, blink, hold and latch logic live in the top.

## Test plan
- Reset, then hold time 12:34:56.78 with running=1 for 8 ticks (SCAN_DIV=1) → after the frame wrap, anode walks FE,FD,…,7F with segments 7'h00(8),7'h78(7),7'h02(6),7'h12(5),7'h19(4),7'h30(3),7'h24(2),7'h79(1). dp=0 only on FB, EF, BF.
- Pulse lap_edge at 00:00:05.00, then advance inputs to 00:00:07.42 → display keeps showing 05.00 and hold=1. A second lap_edge → 07.42 shown after the next frame wrap.
- lap_edge and reset_edge on the same clock with hold=0 → hold stays 0 and all digits show 0 (7'h40).
- running=0 for 1000 ticks (BLINK_HALF=500) → separator DPs lit for ticks 0..499 and dark for 500..999. With running=1, DPs are steady.
- seconds=6'd60 → both seconds digits show 7'h3F while other fields decode normally.
- Assert reset_n low mid-frame at scan_idx=5 → outputs immediately FF/7F/1. After release, the scan restarts at digit 0.
